// File: rtl/if_id_skid.sv
// Fetch-to-decode skid buffer: aligns the synchronous IMEM read word with its PC and squashes wrong-path fetches.
// Latency: one cycle from the advancing edge that samples PC P to id_pc=P / id_inst=mem[P].
// Backpressure: enable=0 or imem_prog_we=1 stalls; the first stalled word is captured so decode sees a stable instruction.
module if_id_skid #(
  parameter int IMEM_ADDR_WIDTH = 9,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       imem_prog_we,
  input  logic                       flush,
  input  logic [IMEM_ADDR_WIDTH-1:0] if_pc,
  input  logic [31:0]                if_inst,
  output logic [31:0]                id_inst,
  output logic [IMEM_ADDR_WIDTH-1:0] id_pc,
  output logic                       id_valid,
  output logic [CNT_WIDTH-1:0]       stall_cnt,
  output logic [CNT_WIDTH-1:0]       squash_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [IMEM_ADDR_WIDTH-1:0] pc_d;
  logic                       fetch_valid;
  logic                       hold_valid;
  logic [31:0]                hold_inst;
  logic                       adv;

  // Advance exactly when the fetch stage updates its PC; everything else is a stall.
  assign adv = enable & ~imem_prog_we;

  // Track the PC/validity of the word on if_inst and capture it on the first stalled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_d        <= '0;
      fetch_valid <= 1'b0;
      hold_valid  <= 1'b0;
      hold_inst   <= 32'h0;
    end else if (adv) begin
      // A redirect on an advancing edge makes the word now being read wrong-path.
      pc_d        <= if_pc;
      fetch_valid <= ~flush;
      hold_valid  <= 1'b0;
    end else if (fetch_valid && !hold_valid) begin
      // Memory output drifts under a held PC (and is garbage while programming), so latch it once.
      hold_inst   <= if_inst;
      hold_valid  <= 1'b1;
    end
  end

  // Saturating statistics: stall edges, and redirects that discarded a live instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else if (adv) begin
      if (flush && id_valid && squash_cnt != CNT_MAX)
        squash_cnt <= squash_cnt + CNT_ONE;
    end else begin
      if (stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Present the held word first, then the live memory word, else a NOP.
  always_comb begin
    id_inst  = 32'h0;
    id_pc    = pc_d;
    id_valid = hold_valid | fetch_valid;
    if (hold_valid)
      id_inst = hold_inst;
    else if (fetch_valid)
      id_inst = if_inst;
  end

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;

  localparam int AW = 9;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          imem_prog_we;
  logic          flush;
  logic [AW-1:0] if_pc;
  logic [31:0]   if_inst;
  logic [31:0]   id_inst;
  logic [AW-1:0] id_pc;
  logic          id_valid;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] squash_cnt;

  if_id_skid #(.IMEM_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .imem_prog_we(imem_prog_we),
    .flush(flush), .if_pc(if_pc), .if_inst(if_inst), .id_inst(id_inst),
    .id_pc(id_pc), .id_valid(id_valid), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  // Fetch stage + instruction memory model
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] fpc;
  logic [AW-1:0] wr_addr;

  // Transaction-level expectation of what decode should see
  logic          exp_valid;
  logic [AW-1:0] exp_pc;
  logic [31:0]   exp_inst;
  int            exp_stall;
  int            exp_squash;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string phase);
    chk({phase, ".valid"},  32'(id_valid),   32'(exp_valid));
    chk({phase, ".pc"},     32'(id_pc),      32'(exp_pc));
    chk({phase, ".inst"},   id_inst,         exp_inst);
    chk({phase, ".stall"},  32'(stall_cnt),  32'(exp_stall));
    chk({phase, ".squash"}, 32'(squash_cnt), 32'(exp_squash));
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_pc     = '0;
    exp_inst   = 32'h0;
    exp_stall  = 0;
    exp_squash = 0;
    fpc        = '0;
    if_pc      = '0;
    if_inst    = 32'h0;
  endtask

  // One clock edge: drive controls, step the fetch model and the expectation, then check.
  task automatic cycle(input logic en, input logic pw, input logic fl,
                       input logic [AW-1:0] tgt, input string phase);
    logic          adv;
    logic [AW-1:0] pc_old;
    enable       = en;
    imem_prog_we = pw;
    flush        = fl;
    adv          = en & ~pw;
    pc_old       = fpc;
    @(posedge clk);
    #1;
    if (adv) begin
      if_inst = mem[pc_old];
      fpc     = fl ? tgt : pc_old + 1'b1;
      exp_pc  = pc_old;
      if (fl) begin
        if (exp_valid && exp_squash < (1 << CW) - 1) exp_squash++;
        exp_valid = 1'b0;
        exp_inst  = 32'h0;
      end else begin
        exp_valid = 1'b1;
        exp_inst  = mem[pc_old];
      end
    end else begin
      if (pw) mem[wr_addr] = $urandom;
      // Memory output is not trustworthy while the PC is held or memory is being written.
      if_inst = $urandom;
      if (exp_stall < (1 << CW) - 1) exp_stall++;
    end
    if_pc = fpc;
    #1;
    check_all(phase);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000 + i;
    enable = 1'b0; imem_prog_we = 1'b0; flush = 1'b0; wr_addr = '0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    @(negedge clk);
    reset = 1'b0;

    // Straight-line fetch: pc 0,1,2,3
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0, "run");
    chk("run.pc3", 32'(id_pc), 32'd3);
    chk("run.inst3", id_inst, 32'h1003);

    // Four stall cycles hold pc 3
    repeat (4) begin
      cycle(1'b0, 1'b0, 1'b0, '0, "stall");
      chk("stall.inst_held", id_inst, 32'h1003);
    end
    chk("stall.cnt4", 32'(stall_cnt), 32'd4);
    cycle(1'b1, 1'b0, 1'b0, '0, "release");
    chk("release.pc4", 32'(id_pc), 32'd4);
    chk("release.inst4", id_inst, 32'h1004);

    // Redirect to 20 while pc 5 is on decode
    cycle(1'b1, 1'b0, 1'b0, '0, "run");
    cycle(1'b1, 1'b0, 1'b1, 9'd20, "flush");
    chk("flush.bubble", 32'(id_valid), 32'd0);
    chk("flush.nop", id_inst, 32'h0);
    chk("flush.squash1", 32'(squash_cnt), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, '0, "target");
    chk("target.pc20", 32'(id_pc), 32'd20);
    chk("target.inst", id_inst, 32'h1014);

    // Redirect to 7, then host programming for three cycles
    cycle(1'b1, 1'b0, 1'b1, 9'd7, "flush7");
    cycle(1'b1, 1'b0, 1'b0, '0, "at7");
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(100 + i);
      cycle(1'b0, 1'b1, 1'b0, '0, "prog");
      chk("prog.inst_held", id_inst, 32'h1007);
    end
    cycle(1'b1, 1'b0, 1'b0, '0, "resume");
    chk("resume.pc8", 32'(id_pc), 32'd8);
    chk("resume.inst", id_inst, 32'h1008);

    // Stall then flush: held word is squashed
    cycle(1'b0, 1'b0, 1'b0, '0, "pre_sf");
    cycle(1'b1, 1'b0, 1'b1, 9'd30, "stall_flush");
    chk("stall_flush.valid", 32'(id_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, '0, "at30");

    // Flush during a stall is ignored by both fetch and this block
    cycle(1'b0, 1'b0, 1'b1, 9'd50, "stall_fl_ign");
    cycle(1'b1, 1'b0, 1'b0, '0, "after_ign");
    chk("after_ign.pc31", 32'(id_pc), 32'd31);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic en, pw, fl;
      en = ($urandom_range(0, 3) != 0);
      pw = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 7) == 0);
      wr_addr = AW'($urandom);
      cycle(en, pw, fl, AW'($urandom), "rand");
    end

    // Saturation of the stall counter
    repeat (20) cycle(1'b0, 1'b0, 1'b0, '0, "sat");
    chk("sat.stall15", 32'(stall_cnt), 32'd15);

    // Reset in the middle of a stall
    enable = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, "post_reset");
    chk("post_reset.pc2", 32'(id_pc), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Fetch-to-decode boundary buffer placed directly after the instruction-fetch stage. The instruction memory has a one-cycle synchronous read, so this block re-aligns each returned instruction word with the PC that fetched it. It keeps the word stable across stalls and host-programming cycles, because the memory output keeps changing underneath a held PC. It also squashes the wrong-path fetch on a branch redirect and presents a single `id_inst`/`id_pc`/`id_valid` triple to decode.

## Interface
Parameters:
- `IMEM_ADDR_WIDTH`, default 9: word-address width of the PC.
- `CNT_WIDTH`, default 16: width of the saturating statistics counters.

Ports:
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset. Asynchronous, active-high.
- `enable` input, 1 bit: pipeline advance. This is the same signal that drives the fetch stage.
- `imem_prog_we` input, 1 bit: host is writing instruction memory. This cycle is treated as a stall.
- `flush` input, 1 bit: branch or jump taken. This is the same signal as the fetch stage's `pc_write`.
- `if_pc` input, `IMEM_ADDR_WIDTH` bits: the fetch stage's current PC, taken before its update.
- `if_inst` input, 32 bits: instruction memory read data, i.e. `mem[pc]` registered at the previous edge.
- `id_inst` output, 32 bits: instruction presented to decode. It is 0 (NOP) when `id_valid`=0.
- `id_pc` output, `IMEM_ADDR_WIDTH` bits: word address of `id_inst`.
- `id_valid` output, 1 bit: `id_inst` is a real, on-path instruction.
- `stall_cnt` output, `CNT_WIDTH` bits: number of stall edges, saturating.
- `squash_cnt` output, `CNT_WIDTH` bits: number of flush edges that squashed a valid instruction, saturating.

## Operation
Internal state:
- `pc_d`: PC of the word currently on `if_inst`.
- `fetch_valid`: `if_inst` holds an on-path word.
- `hold_valid` and `hold_inst`: the captured word.
- The two counters.

Edge classification, at each rising `clk`:
- ADV = `enable` & !`imem_prog_we`. This is the same condition under which the fetch stage updates its PC.
- STALL = !ADV.

ADV edge:
- `pc_d` <= `if_pc`.
- `fetch_valid` <= !`flush`. A word fetched on the same edge as a redirect is wrong-path.
- `hold_valid` <= 0.
- If `flush`=1: also clear the current word, which leaves `id_valid`=0 for the next cycle. Increment `squash_cnt` if `id_valid` was 1.

STALL edge:
- If `fetch_valid` & !`hold_valid`: `hold_inst` <= `if_inst` and `hold_valid` <= 1.
- `pc_d` and `fetch_valid` are unchanged.
- Increment `stall_cnt`.
- `flush` is ignored, because the fetch stage also ignores `pc_write` when it is not advancing.

Outputs are combinational from state:
- `id_inst` = `hold_valid` ? `hold_inst` : (`fetch_valid` ? `if_inst` : 0).
- `id_pc` = `pc_d`.
- `id_valid` = `hold_valid` | `fetch_valid`.

Rules:
- Release: the first ADV edge after a stall drops `hold_valid`. The fetch stage's PC was held during the stall, so the word arriving next is `mem[held PC]`, which is correct. No instruction is lost or duplicated.
- Programming: while `imem_prog_we`=1, `if_inst` is garbage. Because the hold was captured on the first STALL edge, `id_inst` is unaffected.
- Counters saturate at all-ones. They are cleared only by `reset`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `pc_d`=0, `fetch_valid`=0, `hold_valid`=0, `hold_inst`=0, both counters 0.
  - Therefore `id_inst`=0, `id_pc`=0, `id_valid`=0.
- After reset release:
  - First ADV edge: `fetch_valid`=1 and `pc_d`=0.
  - `id_inst`=`mem[0]` is valid in the cycle after that edge.
- Latency: one cycle from the ADV edge that samples PC P to `id_pc`=P with `id_inst`=`mem[P]`.
- Throughput: one instruction per ADV cycle.
- Flush bubble: exactly one `id_valid`=0 cycle after a flush edge. The target instruction appears on the following ADV edge.
- Stall then flush: a STALL edge followed by an ADV edge with flush leaves `hold_valid`=0 and `fetch_valid`=0 after that edge.
- Reset mid-stall discards the held word.

## Test plan
- Reset, then ADV every cycle with `mem[n]`=0x1000+n: `id_pc` steps 0,1,2,… one per cycle. `id_inst` equals 0x1000+`id_pc` and `id_valid`=1 from the second cycle onward.
- With `id_pc`=3, deassert `enable` for 4 cycles: `id_inst` holds 0x1003 and `id_pc` holds 3 throughout. Re-enable: next `id_pc`=4 with `id_inst`=0x1004, no gap, no duplicate. `stall_cnt`=4.
- At `id_pc`=5, assert `flush` for 1 cycle with the fetch stage redirected to 20: next cycle `id_valid`=0 and `id_inst`=0. Then `id_pc`=20 with `id_inst`=0x1014. `squash_cnt`=1.
- At `id_pc`=7, hold `imem_prog_we`=1 for 3 cycles writing addresses 100–102: `id_inst` stays 0x1007. Afterwards `id_pc`=8 with 0x1008 resumes.
- Force `stall_cnt` toward saturation (`CNT_WIDTH`=4, 20 stall cycles): it stops at 15. Assert `reset` mid-stall: all outputs and counters are 0 immediately.
